// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- request/response and bus signal bundle for lsu_ctrl.
//   req_*  : core access request (valid/ready handshake, we, fn4, addr, wdata)
//   rsp_*  : one-cycle response strobe with extended load data and error flag
//   bus_*  : single-outstanding word bus (cyc/we/addr/mask/wdata out, ack/rdata in)
// modport slave  : the load/store unit itself
// modport master : the surrounding core + memory environment
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_fn4;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, req_fn4, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_cyc, bus_we, bus_addr, bus_mask, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_fn4, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_cyc, bus_we, bus_addr, bus_mask, bus_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller: turns byte/half/word core accesses
// into big-endian lane-masked word transfers, extends load data, and abandons
// a transfer after BUS_TIMEOUT cycles without bus_ack.
// Ports: clk, rst (async, active-high), lsu (lsu_ctrl_if.slave).
// Build option: LSU_SPLIT_EN -- when defined, accesses crossing a word
// boundary run as two bus transfers; otherwise they are rejected with rsp_err.
module lsu_ctrl #(
  parameter int BUS_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  lsu
);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS1, BUS2, RESP} state_t;
  state_t state;

  logic [CW-1:0] cnt;
  logic          lat_we, lat_sx;
  logic [1:0]    lat_sz, lat_k;

  logic [7:0]    m8;       // lanes over two words, bit 7 = offset 0 of word A
  logic [63:0]   w64;      // write data positioned over the same two words
  logic          cross_c;
  logic          reject;
  logic [63:0]   rd64;
  logic [31:0]   ld_res;

`ifdef LSU_SPLIT_EN
  logic          lat_cross;
  logic [3:0]    mask2;
  logic [31:0]   wdata2, rd_hi;
`endif

  // Request decode. Working over a two-word window means a crossing access
  // simply spills into the low half; the shift places the first byte at k.
  always_comb begin
    int         w;
    logic [7:0] mb;
    logic [31:0] wm;
    case (lsu.req_fn4[1:0])
      2'd0:    begin w = 1; mb = 8'h80; wm = {24'b0, lsu.req_wdata[7:0]};  end
      2'd1:    begin w = 2; mb = 8'hC0; wm = {16'b0, lsu.req_wdata[15:0]}; end
      default: begin w = 4; mb = 8'hF0; wm = lsu.req_wdata;                end
    endcase
    m8      = mb >> lsu.req_addr[1:0];
    w64     = {32'b0, wm} << (8 * (8 - int'(lsu.req_addr[1:0]) - w));
    cross_c = (int'(lsu.req_addr[1:0]) + w) > 4;
  end

  // Load extraction: bytes sit in address order across rd64; shift the
  // accessed bytes down to the bottom, then extend.
  always_comb begin
    int          wl;
    logic [31:0] v;
    wl   = (lat_sz == 2'd0) ? 1 : (lat_sz == 2'd1) ? 2 : 4;
    rd64 = {lsu.bus_rdata, 32'b0};
`ifdef LSU_SPLIT_EN
    if (state == BUS2) rd64 = {rd_hi, lsu.bus_rdata};
`endif
    v = 32'(rd64 >> (8 * (8 - int'(lat_k) - wl)));
    case (lat_sz)
      2'd0:    ld_res = lat_sx ? {{24{v[7]}}, v[7:0]}   : {24'b0, v[7:0]};
      2'd1:    ld_res = lat_sx ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
      default: ld_res = v;
    endcase
  end

`ifdef LSU_SPLIT_EN
  assign reject = 1'b0;
`else
  assign reject = cross_c;
  // Second-word lanes only matter for split transfers.
  logic unused_lo;
  assign unused_lo = ^{m8[3:0], w64[31:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_sx        <= 1'b0;
      lat_sz        <= '0;
      lat_k         <= '0;
      lsu.req_ready <= 1'b1;
      lsu.rsp_valid <= 1'b0;
      lsu.rsp_rdata <= '0;
      lsu.rsp_err   <= 1'b0;
      lsu.bus_cyc   <= 1'b0;
      lsu.bus_we    <= 1'b0;
      lsu.bus_addr  <= '0;
      lsu.bus_mask  <= '0;
      lsu.bus_wdata <= '0;
`ifdef LSU_SPLIT_EN
      lat_cross     <= 1'b0;
      mask2         <= '0;
      wdata2        <= '0;
      rd_hi         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (lsu.req_valid) begin
          lsu.req_ready <= 1'b0;
          lat_we        <= lsu.req_we;
          lat_sx        <= lsu.req_fn4[3];
          lat_sz        <= lsu.req_fn4[1:0];
          lat_k         <= lsu.req_addr[1:0];
          if (reject) begin
            state         <= RESP;
            lsu.rsp_valid <= 1'b1;
            lsu.rsp_err   <= 1'b1;
            lsu.rsp_rdata <= '0;
          end else begin
            state         <= BUS1;
            cnt           <= '0;
            lsu.bus_cyc   <= 1'b1;
            lsu.bus_we    <= lsu.req_we;
            lsu.bus_addr  <= {lsu.req_addr[31:2], 2'b00};
            lsu.bus_mask  <= m8[7:4];
            lsu.bus_wdata <= lsu.req_we ? w64[63:32] : '0;
`ifdef LSU_SPLIT_EN
            lat_cross     <= cross_c;
            mask2         <= m8[3:0];
            wdata2        <= lsu.req_we ? w64[31:0] : '0;
`endif
          end
        end

        BUS1, BUS2: begin
`ifdef LSU_SPLIT_EN
          if (lsu.bus_ack && state == BUS1 && lat_cross) begin
            state         <= BUS2;
            cnt           <= '0;
            rd_hi         <= lsu.bus_rdata;
            lsu.bus_addr  <= lsu.bus_addr + 32'd4;
            lsu.bus_mask  <= mask2;
            lsu.bus_wdata <= wdata2;
          end else
`endif
          // ack is tested first so it wins over a coincident timeout
          if (lsu.bus_ack || cnt == CW'(BUS_TIMEOUT - 1)) begin
            state         <= RESP;
            lsu.bus_cyc   <= 1'b0;
            lsu.rsp_valid <= 1'b1;
            lsu.rsp_err   <= !lsu.bus_ack;
            lsu.rsp_rdata <= (lsu.bus_ack && !lat_we) ? ld_res : '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RESP: begin
          state         <= IDLE;
          lsu.rsp_valid <= 1'b0;
          lsu.rsp_err   <= 1'b0;
          lsu.rsp_rdata <= '0;
          lsu.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed self-checking bench for lsu_ctrl (BUS_TIMEOUT = 64).
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if lsu ();
  lsu_ctrl #(.BUS_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .lsu(lsu.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] fn4,
                       input logic [31:0] addr, input logic [31:0] wdata);
    lsu.req_valid = 1'b1;
    lsu.req_we    = we;
    lsu.req_fn4   = fn4;
    lsu.req_addr  = addr;
    lsu.req_wdata = wdata;
    step();
    lsu.req_valid = 1'b0;
    lsu.req_addr  = 32'hDEAD_BEEF;  // must be ignored once latched
    lsu.req_wdata = 32'h5555_5555;
  endtask

  // One non-crossing access with `waits` wait states, checking bus view and response.
  task automatic access(input string tag, input logic we, input logic [3:0] fn4,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits,
                        input logic [31:0] e_addr, input logic [3:0] e_mask,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    issue(we, fn4, addr, wdata);
    chk({tag, "_cyc"},   lsu.bus_cyc,   1);
    chk({tag, "_ready"}, lsu.req_ready, 0);
    chk({tag, "_we"},    lsu.bus_we,    we);
    chk({tag, "_addr"},  lsu.bus_addr,  e_addr);
    chk({tag, "_mask"},  lsu.bus_mask,  e_mask);
    if (we) chk({tag, "_wdata"}, lsu.bus_wdata, e_wdata);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_wcyc"},  lsu.bus_cyc,   1);
      chk({tag, "_waddr"}, lsu.bus_addr,  e_addr);
      chk({tag, "_wmask"}, lsu.bus_mask,  e_mask);
      chk({tag, "_wrsp"},  lsu.rsp_valid, 0);
    end
    lsu.bus_ack   = 1'b1;
    lsu.bus_rdata = rdata;
    step();
    lsu.bus_ack   = 1'b0;
    lsu.bus_rdata = 32'h0;
    chk({tag, "_rsp"},   lsu.rsp_valid, 1);
    chk({tag, "_err"},   lsu.rsp_err,   0);
    chk({tag, "_rdata"}, lsu.rsp_rdata, e_rdata);
    chk({tag, "_cycdn"}, lsu.bus_cyc,   0);
    step();
    chk({tag, "_rspdn"}, lsu.rsp_valid, 0);
    chk({tag, "_idle"},  lsu.req_ready, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    lsu.req_valid = 1'b0; lsu.req_we = 1'b0; lsu.req_fn4 = 4'h0;
    lsu.req_addr = 32'h0; lsu.req_wdata = 32'h0;
    lsu.bus_ack = 1'b0;   lsu.bus_rdata = 32'h0;
    #17;
    chk("rst_ready", lsu.req_ready, 1);
    chk("rst_rsp",   lsu.rsp_valid, 0);
    chk("rst_rdata", lsu.rsp_rdata, 0);
    chk("rst_err",   lsu.rsp_err,   0);
    chk("rst_cyc",   lsu.bus_cyc,   0);
    chk("rst_mask",  lsu.bus_mask,  0);
    chk("rst_addr",  lsu.bus_addr,  0);
    @(negedge clk);
    rst = 1'b0;

    // Signed byte load, accepted on the first edge after reset release.
    access("ldb_s", 0, 4'h8, 32'h0000_0101, 0, 32'h1280_3456, 0,
           32'h0000_0100, 4'b0100, 0, 32'hFFFF_FF80);
    // Store half at k=2 with one wait state.
    access("sth", 1, 4'h1, 32'h0000_0202, 32'hAAAA_BEEF, 32'hDEAD_BEEF, 1,
           32'h0000_0200, 4'b0011, 32'h0000_BEEF, 0);
    access("ldh_s1", 0, 4'h9, 32'h0000_1001, 0, 32'h11F2_3344, 0,
           32'h0000_1000, 4'b0110, 0, 32'hFFFF_F233);
    access("ldh_u2", 0, 4'h1, 32'h0000_1002, 0, 32'h1234_8765, 2,
           32'h0000_1000, 4'b0011, 0, 32'h0000_8765);
    access("ldh_s0", 0, 4'h9, 32'h0000_2000, 0, 32'h8001_7777, 0,
           32'h0000_2000, 4'b1100, 0, 32'hFFFF_8001);
    access("ldb_u3", 0, 4'h0, 32'h0000_3003, 0, 32'h1122_33C5, 0,
           32'h0000_3000, 4'b0001, 0, 32'h0000_00C5);
    access("ldw", 0, 4'hA, 32'h0000_4000, 0, 32'h89AB_CDEF, 0,
           32'h0000_4000, 4'b1111, 0, 32'h89AB_CDEF);
    access("stb1", 1, 4'h0, 32'h0000_5001, 32'h1234_56A5, 0, 0,
           32'h0000_5000, 4'b0100, 32'h00A5_0000, 0);
    access("stw", 1, 4'h2, 32'h0000_6000, 32'hCAFE_F00D, 0, 0,
           32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 0);
    access("sth0", 1, 4'h1, 32'h0000_7000, 32'h0000_1357, 0, 0,
           32'h0000_7000, 4'b1100, 32'h1357_0000, 0);

    // Stray ack while idle does nothing.
    lsu.bus_ack = 1'b1;
    step();
    lsu.bus_ack = 1'b0;
    chk("stray_rsp",   lsu.rsp_valid, 0);
    chk("stray_cyc",   lsu.bus_cyc,   0);
    chk("stray_ready", lsu.req_ready, 1);

    // Timeout: bus_cyc stays up for exactly 64 cycles.
    issue(0, 4'h2, 32'h0000_0010, 0);
    n = 0;
    while (lsu.bus_cyc === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("to_cycles", n, 64);
    chk("to_rsp",    lsu.rsp_valid, 1);
    chk("to_err",    lsu.rsp_err,   1);
    chk("to_rdata",  lsu.rsp_rdata, 0);
    step();
    chk("to_idle",   lsu.req_ready, 1);

    // Ack on the final timeout cycle wins.
    issue(0, 4'h2, 32'h0000_0020, 0);
    repeat (63) step();
    chk("tw_cyc", lsu.bus_cyc, 1);
    lsu.bus_ack = 1'b1; lsu.bus_rdata = 32'h5A5A_1234;
    step();
    lsu.bus_ack = 1'b0; lsu.bus_rdata = 32'h0;
    chk("tw_rsp",   lsu.rsp_valid, 1);
    chk("tw_err",   lsu.rsp_err,   0);
    chk("tw_rdata", lsu.rsp_rdata, 32'h5A5A_1234);
    step();

`ifdef LSU_SPLIT_EN
    // Split load word at 0x103.
    issue(0, 4'h2, 32'h0000_0103, 0);
    chk("spl_addr1", lsu.bus_addr, 32'h0000_0100);
    chk("spl_mask1", lsu.bus_mask, 4'b0001);
    lsu.bus_ack = 1'b1; lsu.bus_rdata = 32'h0000_00AB;
    step();
    chk("spl_cyc2",  lsu.bus_cyc,   1);
    chk("spl_addr2", lsu.bus_addr,  32'h0000_0104);
    chk("spl_mask2", lsu.bus_mask,  4'b1110);
    chk("spl_rsp1",  lsu.rsp_valid, 0);
    lsu.bus_rdata = 32'hCDEF_0100;
    step();
    lsu.bus_ack = 1'b0; lsu.bus_rdata = 32'h0;
    chk("spl_rsp",   lsu.rsp_valid, 1);
    chk("spl_rdata", lsu.rsp_rdata, 32'hABCD_EF01);
    step();
    // Split store word at 0x103, BUS2 times out.
    issue(1, 4'h2, 32'h0000_0103, 32'h1122_3344);
    chk("sps_wd1", lsu.bus_wdata, 32'h0000_0011);
    lsu.bus_ack = 1'b1;
    step();
    lsu.bus_ack = 1'b0;
    chk("sps_wd2",   lsu.bus_wdata, 32'h2233_4400);
    chk("sps_mask2", lsu.bus_mask,  4'b1110);
    repeat (64) step();
    chk("sps_rsp", lsu.rsp_valid, 1);
    chk("sps_err", lsu.rsp_err,   1);
    step();
`else
    // Crossing store is rejected without a bus transfer.
    issue(1, 4'h2, 32'h0000_0103, 32'h1122_3344);
    chk("x_cyc",   lsu.bus_cyc,   0);
    chk("x_rsp",   lsu.rsp_valid, 1);
    chk("x_err",   lsu.rsp_err,   1);
    chk("x_rdata", lsu.rsp_rdata, 0);
    step();
    chk("x_idle",  lsu.req_ready, 1);
    chk("x_rspdn", lsu.rsp_valid, 0);
    issue(0, 4'h1, 32'h0000_0203, 0);
    chk("xh_cyc", lsu.bus_cyc,   0);
    chk("xh_err", lsu.rsp_err,   1);
    step();
`endif

    // Asynchronous reset during a BUS1 wait state.
    issue(0, 4'h2, 32'h0000_0300, 0);
    step();
    chk("ar_pre", lsu.bus_cyc, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_cyc",   lsu.bus_cyc,   0);
    chk("ar_ready", lsu.req_ready, 1);
    chk("ar_rsp",   lsu.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    access("post_rst", 0, 4'h2, 32'h0000_0400, 0, 32'h0BAD_F00D, 1,
           32'h0000_0400, 4'b1111, 0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter BUS_TIMEOUT, default 64: the number of bus cycles to wait for bus_ack before the transfer is abandoned.
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset; asynchronous and active-high.
REQ-004 Port req_valid, input, 1: the core presents an access.
REQ-005 Port req_ready, output, 1: the block can accept an access.
REQ-006 Port req_we, input, 1: 1 = store, 0 = load.
REQ-007 Port req_fn4, input, 4: bits [1:0] give the size (0 byte, 1 half, 2/3 word); bit 3 = sign-extend the load.
REQ-008 Port req_addr, input, 32: byte address.
REQ-009 Port req_wdata, input, 32: store data, right-justified.
REQ-010 Port rsp_valid, output, 1: response strobe, one cycle wide.
REQ-011 Port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-012 Port rsp_err, output, 1: the access failed; qualified by rsp_valid.
REQ-013 Port bus_cyc, output, 1: a bus transfer is active.
REQ-014 Port bus_we, output, 1: bus write.
REQ-015 Port bus_addr, output, 32: word address; bits [1:0] are always 0.
REQ-016 Port bus_mask, output, 4: byte lanes; bit 3 = bits [31:24] = byte offset 0 (big-endian).
REQ-017 Port bus_wdata, output, 32: lane-positioned write data; unused lanes are 0.
REQ-018 Port bus_ack, input, 1: the current transfer is complete.
REQ-019 Port bus_rdata, input, 32: read data; valid on the bus_ack cycle.

Function
REQ-020 The FSM SHALL have four states: IDLE, BUS1, BUS2, RESP; req_ready = 1 only in IDLE.
REQ-021 An access SHALL be accepted on req_valid & req_ready, with all request fields latched; the request inputs SHALL be ignored until the next IDLE.
REQ-022 Lane mask for an access of width w (1/2/4 bytes) at offset k = addr[1:0]: bits (3-k) down to (4-k-w) set; half k=0/1/2 → 1100/0110/0011, byte k → 1000>>k.
REQ-023 An access SHALL be "crossing" when k + w > 4 (half at k=3, word at k≠0); a non-crossing access goes IDLE→BUS1→RESP.
REQ-024 In BUS1/BUS2: bus_cyc = 1, with addr/we/mask/wdata held stable until the bus_ack cycle; bus_cyc falls the cycle after bus_ack.
REQ-025 bus_ack outside BUS1/BUS2 SHALL be ignored.
REQ-026 Load result: the accessed bytes are concatenated in address order (first byte most significant), then sign-extended if fn4[3] is set, else zero-extended; a word load is unmodified.
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-028 Latency: accept at cycle N, bus_cyc at N+1; with bus_ack at N+1, rsp_valid at N+2; each wait state adds one cycle.
REQ-029 A per-transfer wait counter SHALL clear on entry to BUS1/BUS2.
REQ-030 If BUS_TIMEOUT cycles elapse without bus_ack: bus_cyc drops, go to RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-031 bus_ack arriving in the same cycle as the timeout expires SHALL win, and the transfer completes normally.

Reset
REQ-032 rst SHALL force IDLE immediately, mid-transfer included; req_ready = 1, every other output = 0, counter = 0.
REQ-033 After rst deasserts, the first access can be accepted on the first rising clk edge.

Configuration
REQ-034 Macro LSU_SPLIT_EN, when defined: a crossing access SHALL run BUS1 at word A = addr & ~3 with the upper-offset lanes, then BUS2 at A+4 (mod 2^32) with the remaining lanes.
REQ-035 With LSU_SPLIT_EN, load bytes from both transfers merge per REQ-026, and store bytes are split in address order across the two transfers.
REQ-036 With LSU_SPLIT_EN, a timeout in BUS2 SHALL report rsp_err = 1; the BUS1 write stays committed.
REQ-037 Without LSU_SPLIT_EN: a crossing access SHALL go IDLE→RESP with rsp_err = 1 and no bus_cyc; BUS2 is unreachable.

Verification
REQ-038 Load byte, fn4 = 8, addr 0x101, bus_rdata 0x1280_3456, ack immediate → mask 0100, rsp_rdata 0xFFFF_FF80, rsp_valid at N+2.
REQ-039 Store half, fn4 = 1, addr 0x202, wdata 0xAAAA_BEEF → bus_addr 0x200, mask 0011, bus_wdata 0x0000_BEEF.
REQ-040 Load word, addr 0x10, bus_ack withheld, BUS_TIMEOUT = 64 → bus_cyc high for 64 cycles, then rsp_err = 1, rsp_rdata = 0.
REQ-041 With LSU_SPLIT_EN: load word at addr 0x103 with rdata 0x0000_00AB then 0xCDEF_0100 → bus_addr 0x100 mask 0001, then 0x104 mask 1110; rsp_rdata 0xABCD_EF01.
REQ-042 Without LSU_SPLIT_EN: store word at addr 0x103 → no bus_cyc, rsp_valid with rsp_err = 1 at N+1.
REQ-043 rst asserted during BUS1 with a wait state → bus_cyc = 0 asynchronously; a subsequent access completes normally.
